// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latrnq_bank.sv
// gf180mcu_fd_sc_mcu7t5v0__latrnq_bank: lane-enabled, scan-shiftable resettable register bank
//   CLK   rising-edge clock
//   RN    asynchronous active-low reset
//   E     per-lane load enable (functional mode)
//   D     parallel load data
//   SE    scan enable (1 = shift, 0 = functional)
//   SI    serial input entering at Q[0]
//   Q     stored word
//   SO    serial output, always Q[WIDTH-1]
//   CHG   per-lane pulse when a load changed the lane contents
//   SDONE pulse after WIDTH consecutive shift edges
//   PAR   per-lane even parity of Q (only with GF180MCU_LATRNQ_BANK_PARITY_EN defined)
module gf180mcu_fd_sc_mcu7t5v0__latrnq_bank #(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [LANES-1:0] E,
    input  logic [WIDTH-1:0] D,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
`ifdef GF180MCU_LATRNQ_BANK_PARITY_EN
    output logic [LANES-1:0] PAR,
`endif
    output logic             SO,
    output logic [LANES-1:0] CHG,
    output logic             SDONE
);
    localparam int LW = WIDTH / LANES;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [LANES-1:0] chg_q, chg_d;
    logic             sdone_q, sdone_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        q_d     = q_q;
        chg_d   = '0;
        sdone_d = 1'b0;
        cnt_d   = '0;
        if (SE) begin
            // shift form that also holds for WIDTH=1
            q_d     = (q_q << 1) | WIDTH'(SI);
            sdone_d = cnt_q == CNT_LAST;
            cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                chg_d[i] = E[i] && (D[i*LW +: LW] != q_q[i*LW +: LW]);
                if (E[i]) q_d[i*LW +: LW] = D[i*LW +: LW];
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            q_q     <= RESET_VAL;
            chg_q   <= '0;
            sdone_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            q_q     <= q_d;
            chg_q   <= chg_d;
            sdone_q <= sdone_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Q     = q_q;
    assign SO    = q_q[WIDTH-1];
    assign CHG   = chg_q;
    assign SDONE = sdone_q;

`ifdef GF180MCU_LATRNQ_BANK_PARITY_EN
    function automatic logic [LANES-1:0] lane_par(input logic [WIDTH-1:0] v);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) p[i] = ^v[i*LW +: LW];
        return p;
    endfunction

    logic [LANES-1:0] par_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) par_q <= lane_par(RESET_VAL);
        else     par_q <= lane_par(q_d);
    end

    assign PAR = par_q;
`endif
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__latrnq_bank.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__latrnq_bank: directed self-checking bench for the register bank
module tb_gf180mcu_fd_sc_mcu7t5v0__latrnq_bank;
    localparam logic [7:0] RV = 8'hA5;

    logic       CLK = 1'b0;
    logic       RN = 1'b0;
    logic [1:0] E = '0;
    logic [7:0] D = '0;
    logic       SE = 1'b0;
    logic       SI = 1'b0;
    logic [7:0] Q;
    logic       SO;
    logic [1:0] CHG;
    logic       SDONE;
`ifdef GF180MCU_LATRNQ_BANK_PARITY_EN
    logic [1:0] PAR;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    gf180mcu_fd_sc_mcu7t5v0__latrnq_bank #(.WIDTH(8), .LANES(2), .RESET_VAL(RV)) dut (
        .CLK(CLK), .RN(RN), .E(E), .D(D), .SE(SE), .SI(SI), .Q(Q),
`ifdef GF180MCU_LATRNQ_BANK_PARITY_EN
        .PAR(PAR),
`endif
        .SO(SO), .CHG(CHG), .SDONE(SDONE)
    );

    always #5 CLK = ~CLK;

    // reference model: word value, change flags, and length of the current shift run
    logic [7:0] mq = RV;
    logic [1:0] mchg = '0;
    logic       msdone = 1'b0;
    int         run = 0;

    always @(posedge CLK or negedge RN) begin
        if (!RN) begin
            mq = RV; mchg = '0; msdone = 1'b0; run = 0;
        end else if (SE) begin
            mq = {mq[6:0], SI};
            mchg = '0;
            run = run + 1;
            msdone = (run % 8) == 0;
        end else begin
            mchg[0] = E[0] && (D[3:0] != mq[3:0]);
            mchg[1] = E[1] && (D[7:4] != mq[7:4]);
            if (E[0]) mq[3:0] = D[3:0];
            if (E[1]) mq[7:4] = D[7:4];
            run = 0;
            msdone = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (checking) begin
            check("model_Q", 32'(Q), 32'(mq));
            check("model_SO", 32'(SO), 32'(mq[7]));
            check("model_CHG", 32'(CHG), 32'(mchg));
            check("model_SDONE", 32'(SDONE), 32'(msdone));
`ifdef GF180MCU_LATRNQ_BANK_PARITY_EN
            check("model_PAR", 32'(PAR), 32'({^mq[7:4], ^mq[3:0]}));
`endif
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_pulse(input string name);
        RN = 1'b0;
        #1;
        check({name, "_Q"}, 32'(Q), 32'hA5);
        check({name, "_SO"}, 32'(SO), 32'h1);
        check({name, "_CHG"}, 32'(CHG), 32'h0);
        check({name, "_SDONE"}, 32'(SDONE), 32'h0);
`ifdef GF180MCU_LATRNQ_BANK_PARITY_EN
        check({name, "_PAR"}, 32'(PAR), 32'h0);
`endif
        RN = 1'b1;
        #1;
    endtask

    task automatic shifts(input int n, input int done_at, input string name);
        SE = 1'b1;
        for (int i = 1; i <= n; i++) begin
            SI = 1'($urandom);
            tick();
            check(name, 32'(SDONE), 32'(i == done_at));
        end
    endtask

    initial begin
        logic [7:0] si_seq = 8'b1011_0001;
        logic [7:0] so_seq = 8'b1010_0101;
        tick();
        tick();
        check("por_Q", 32'(Q), 32'hA5);
        check("por_SDONE", 32'(SDONE), 32'h0);
        RN = 1'b1;
        checking = 1'b1;
        E = 2'b11; D = 8'h00;
        tick();
        check("clear_Q", 32'(Q), 32'h00);
        E = 2'b00;
        reset_pulse("async_rst");
        tick();
        E = 2'b01; D = 8'h3C;
        tick();
        check("load_Q", 32'(Q), 32'hAC);
        check("load_CHG", 32'(CHG), 32'h1);
        tick();
        check("reload_Q", 32'(Q), 32'hAC);
        check("reload_CHG", 32'(CHG), 32'h0);
        E = 2'b00;
        reset_pulse("pre_shift_rst");
        SE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("shift_SO", 32'(SO), 32'(so_seq[7-i]));
            SI = si_seq[7-i];
            tick();
            check("shift_SDONE", 32'(SDONE), 32'(i == 7));
        end
        check("shift_Q", 32'(Q), 32'hB1);
        SE = 1'b0;
        tick();
        check("shift_end_SDONE", 32'(SDONE), 32'h0);
        shifts(5, 0, "abort_first_SDONE");
        SE = 1'b0;
        tick();
        check("abort_gap_SDONE", 32'(SDONE), 32'h0);
        shifts(8, 8, "abort_second_SDONE");
        shifts(8, 8, "continuous_SDONE");
        E = 2'b11; D = 8'hFF; SI = 1'b0; SE = 1'b1;
        tick();
        check("conflict_CHG", 32'(CHG), 32'h0);
        vectors++;
        if (Q === 8'hFF) begin
            miscompares++;
            $display("FAIL conflict_Q: got %0h expected not ff", Q);
        end
        SE = 1'b0; E = 2'b00;
        tick();
        shifts(4, 0, "pre_rst_SDONE");
        reset_pulse("mid_shift_rst");
        shifts(8, 8, "post_rst_SDONE");
        SE = 1'b0;
        for (int i = 0; i < 24; i++) begin
            E = 2'($urandom);
            D = 8'($urandom);
            SE = ($urandom_range(0, 3) == 0);
            SI = 1'($urandom);
            tick();
        end
        SE = 1'b0; E = 2'b00;
        tick();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
